counter_mod: RTL and testbench

- Parametrised successor to the team's 4-bit enable counter.
- Provides configurable width and modulus, up/down direction, synchronous clear and load, wrap or saturate mode, a registered wrap pulse and a sticky overflow flag.
- Used as the general-purpose event/timebase counter in the 12 MHz clock domain.
- Instantiated by timers, LED dividers and test benches in place of fixed-width counters.

---
 rtl/counter_mod.sv | 107 ++++++++++
 tb/tb_counter_mod.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/counter_mod.sv
// Parametrised up/down modulo counter with clear, load, wrap/saturate modes, wrap pulse and
// sticky overflow. Optional en-cycle prescaler enabled by defining COUNTER_PRESCALE_EN.
module counter_mod #(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MODULO   = 16,
    parameter int unsigned     SATURATE = 0,
    parameter int unsigned     PRESCALE = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap,
    output logic             ovf
);

    // Terminal count; equals all-ones when MODULO == 2**WIDTH, so wrap is natural overflow.
    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULO - 64'd1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] ld_clamped;
    logic             at_term;
    logic             step;

`ifdef COUNTER_PRESCALE_EN
    localparam int unsigned        PsWidth = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PsWidth-1:0] PsLast  = PsWidth'(PRESCALE - 1);

    logic [PsWidth-1:0] ps_q, ps_d;

    always_comb begin
        ps_d = ps_q;
        if (clr || load) begin
            ps_d = '0;
        end else if (en) begin
            ps_d = (ps_q == PsLast) ? '0 : ps_q + PsWidth'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

    assign step = en && (ps_q == PsLast);
`else
    assign step = en;
`endif

    always_comb begin
        at_term    = up_dn ? (cnt_q == MaxVal) : (cnt_q == '0);
        ld_clamped = (ld_val > MaxVal) ? MaxVal : ld_val;

        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q;

        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (load) begin
            cnt_d = ld_clamped;
        end else if (step) begin
            if (at_term) begin
                // Pulse in both modes; saturate mode simply leaves cnt at the terminal value.
                wrap_d = 1'b1;
                ovf_d  = 1'b1;
                if (SATURATE == 0) begin
                    cnt_d = up_dn ? '0 : MaxVal;
                end
            end else begin
                cnt_d = up_dn ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign cnt  = cnt_q;
    assign wrap = wrap_q;
    assign ovf  = ovf_q;

`ifndef SYNTHESIS
    cnt_in_range_a : assert property (@(posedge clk) disable iff (!reset_n) cnt_q <= MaxVal);
    wrap_sets_ovf_a : assert property (@(posedge clk) disable iff (!reset_n) wrap_q |-> ovf_q);
`endif

endmodule

// File: tb/tb_counter_mod.sv
// Self-checking bench for counter_mod: a wrap-mode and a saturate-mode instance (WIDTH=4,
// MODULO=10) share stimulus; expectations travel through a scoreboard queue.
module tb_counter_mod;

    logic       clk = 1'b0;
    logic       reset_n, en, up_dn, clr, load;
    logic [3:0] ld_val;
    logic [3:0] cnt_w, cnt_s;
    logic       wrap_w, wrap_s, ovf_w, ovf_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    counter_mod #(.WIDTH(4), .MODULO(10), .SATURATE(0), .PRESCALE(3)) u_wrap (
        .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .ld_val(ld_val), .cnt(cnt_w), .wrap(wrap_w), .ovf(ovf_w)
    );

    counter_mod #(.WIDTH(4), .MODULO(10), .SATURATE(1), .PRESCALE(3)) u_sat (
        .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .ld_val(ld_val), .cnt(cnt_s), .wrap(wrap_s), .ovf(ovf_s)
    );

    typedef struct {
        logic       rn, c, l, e, ud;
        logic [3:0] ldv;
        logic [3:0] cw;
        logic       ww, ow;
        logic [3:0] cs;
        logic       ws, os;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] cw;
        logic       ww, ow;
        logic [3:0] cs;
        logic       ws, os;
    } exp_t;

    exp_t sb_q[$];

    function automatic vec_t mk(logic rn, logic c, logic l, logic e, logic ud, int ldv,
                                int cw, int ww, int ow, int cs, int ws, int os);
        vec_t v;
        v.rn = rn; v.c = c; v.l = l; v.e = e; v.ud = ud; v.ldv = 4'(ldv);
        v.cw = 4'(cw); v.ww = 1'(ww); v.ow = 1'(ow);
        v.cs = 4'(cs); v.ws = 1'(ws); v.os = 1'(os);
        return v;
    endfunction

    task automatic check(string name, string sig, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s %s: got %0h, expected %0h", name, sig, act, req);
        end
    endtask

    task automatic compare_pop();
        exp_t ex;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        ex = sb_q.pop_front();
        check(ex.name, "cnt_wrapmode",  32'(cnt_w),  32'(ex.cw));
        check(ex.name, "wrap_wrapmode", 32'(wrap_w), 32'(ex.ww));
        check(ex.name, "ovf_wrapmode",  32'(ovf_w),  32'(ex.ow));
        check(ex.name, "cnt_satmode",   32'(cnt_s),  32'(ex.cs));
        check(ex.name, "wrap_satmode",  32'(wrap_s), 32'(ex.ws));
        check(ex.name, "ovf_satmode",   32'(ovf_s),  32'(ex.os));
    endtask

    task automatic drive(string name, vec_t v);
        exp_t ex;
        @(negedge clk);
        reset_n = v.rn; clr = v.c; load = v.l; en = v.e; up_dn = v.ud; ld_val = v.ldv;
        ex.name = name;
        ex.cw = v.cw; ex.ww = v.ww; ex.ow = v.ow;
        ex.cs = v.cs; ex.ws = v.ws; ex.os = v.os;
        sb_q.push_back(ex);
        @(posedge clk);
        #1;
        compare_pop();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; ld_val = '0;

`ifndef COUNTER_PRESCALE_EN
        begin
            vec_t vecs[27];
            //            rn c  l  e  ud ldv  cW wW oW  cS wS oS
            vecs[0]  = mk(0, 0, 0, 1, 1, 0,   0, 0, 0,  0, 0, 0);
            vecs[1]  = mk(0, 0, 0, 1, 1, 0,   0, 0, 0,  0, 0, 0);
            vecs[2]  = mk(1, 0, 0, 1, 1, 0,   1, 0, 0,  1, 0, 0);
            vecs[3]  = mk(1, 0, 1, 1, 1, 8,   8, 0, 0,  8, 0, 0);
            vecs[4]  = mk(1, 0, 0, 1, 1, 0,   9, 0, 0,  9, 0, 0);
            vecs[5]  = mk(1, 0, 0, 1, 1, 0,   0, 1, 1,  9, 1, 1);
            vecs[6]  = mk(1, 0, 0, 1, 1, 0,   1, 0, 1,  9, 1, 1);
            vecs[7]  = mk(1, 0, 0, 0, 1, 0,   1, 0, 1,  9, 0, 1);
            vecs[8]  = mk(1, 0, 1, 0, 1, 5,   5, 0, 1,  5, 0, 1);
            vecs[9]  = mk(1, 1, 1, 1, 1, 7,   0, 0, 0,  0, 0, 0);
            vecs[10] = mk(1, 0, 1, 0, 1, 12,  9, 0, 0,  9, 0, 0);
            vecs[11] = mk(1, 0, 1, 1, 1, 15,  9, 0, 0,  9, 0, 0);
            vecs[12] = mk(1, 0, 1, 0, 0, 2,   2, 0, 0,  2, 0, 0);
            vecs[13] = mk(1, 0, 0, 1, 0, 0,   1, 0, 0,  1, 0, 0);
            vecs[14] = mk(1, 0, 0, 1, 0, 0,   0, 0, 0,  0, 0, 0);
            vecs[15] = mk(1, 0, 0, 1, 0, 0,   9, 1, 1,  0, 1, 1);
            vecs[16] = mk(1, 0, 0, 1, 0, 0,   8, 0, 1,  0, 1, 1);
            vecs[17] = mk(1, 0, 0, 1, 1, 0,   9, 0, 1,  1, 0, 1);
            vecs[18] = mk(1, 0, 1, 0, 1, 5,   5, 0, 1,  5, 0, 1);
            vecs[19] = mk(1, 0, 0, 1, 1, 0,   6, 0, 1,  6, 0, 1);
            vecs[20] = mk(0, 0, 0, 1, 1, 0,   0, 0, 0,  0, 0, 0);
            vecs[21] = mk(1, 0, 0, 1, 1, 0,   1, 0, 0,  1, 0, 0);
            vecs[22] = mk(1, 0, 0, 1, 1, 0,   2, 0, 0,  2, 0, 0);
            vecs[23] = mk(1, 0, 1, 0, 1, 9,   9, 0, 0,  9, 0, 0);
            vecs[24] = mk(1, 0, 0, 1, 1, 0,   0, 1, 1,  9, 1, 1);
            vecs[25] = mk(1, 0, 1, 1, 1, 3,   3, 0, 1,  3, 0, 1);
            vecs[26] = mk(1, 1, 0, 0, 1, 0,   0, 0, 0,  0, 0, 0);

            for (int i = 0; i < 27; i++) begin
                drive($sformatf("vec%0d", i), vecs[i]);
            end

            // Long up-count from 0: wrap instance cycles mod 10, saturate instance sticks at 9.
            for (int i = 1; i <= 25; i++) begin
                drive($sformatf("run%0d", i),
                      mk(1, 0, 0, 1, 1, 0,
                         i % 10, (i % 10 == 0) ? 1 : 0, (i >= 10) ? 1 : 0,
                         (i > 9) ? 9 : i, (i >= 10) ? 1 : 0, (i >= 10) ? 1 : 0));
            end
        end
`else
        drive("ps_rst0", mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        drive("ps_rst1", mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        drive("ps_clr",  mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 9; i++) begin
            drive($sformatf("ps_run%0d", i), mk(1, 0, 0, 1, 1, 0, i / 3, 0, 0, i / 3, 0, 0));
        end
        drive("ps_gap0", mk(1, 0, 0, 1, 1, 0, 3, 0, 0, 3, 0, 0));
        drive("ps_gap1", mk(1, 0, 0, 1, 1, 0, 3, 0, 0, 3, 0, 0));
        drive("ps_gap2", mk(1, 0, 0, 0, 1, 0, 3, 0, 0, 3, 0, 0));
        drive("ps_gap3", mk(1, 0, 0, 0, 1, 0, 3, 0, 0, 3, 0, 0));
        drive("ps_gap4", mk(1, 0, 0, 1, 1, 0, 4, 0, 0, 4, 0, 0));
        drive("ps_ld0",  mk(1, 0, 0, 1, 1, 0, 4, 0, 0, 4, 0, 0));
        drive("ps_ld1",  mk(1, 0, 1, 1, 1, 5, 5, 0, 0, 5, 0, 0));
        drive("ps_ld2",  mk(1, 0, 0, 1, 1, 0, 5, 0, 0, 5, 0, 0));
        drive("ps_ld3",  mk(1, 0, 0, 1, 1, 0, 5, 0, 0, 5, 0, 0));
        drive("ps_ld4",  mk(1, 0, 0, 1, 1, 0, 6, 0, 0, 6, 0, 0));
`endif

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries, expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
